// File: rtl/haze_pkg.sv
// Shared constants and FSM encoding for the haze-removal stream scheduler.
package haze_pkg;

  localparam int         HAZE_DATA_W = 24;
  localparam int         HAZE_TX_W   = 8;
  localparam int         HAZE_ADDR_W = 11;
  localparam logic [7:0] HAZE_A_INIT = 8'd240;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CHECK = 2'd3
  } sched_state_t;

endpackage

// File: rtl/haze_sync_fifo.sv
// Single-clock FIFO on a simple dual-port RAM with a 1-cycle registered read.
// A pop on an empty FIFO returns zero; a push while full is accepted only if a pop frees a slot.
module haze_sync_fifo #(
  parameter int DW = 24,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          flush,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = rd_en && !empty;
  assign push_ok = wr_en && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (!push_ok && pop_ok) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= empty ? '0 : mem[rptr];
  end

endmodule

// File: rtl/haze_stream_sched.sv
// Aligns buffered source pixels with the delayed transmission stream and frame-locks A.
// Optional per-frame FIFO high-water mark on hwm: define HAZE_SCHED_HWM_EN.
module haze_stream_sched
  import haze_pkg::*;
#(
  parameter int         DATA_W = HAZE_DATA_W,
  parameter int         TX_W   = HAZE_TX_W,
  parameter int         ADDR_W = HAZE_ADDR_W,
  parameter logic [7:0] A_INIT = HAZE_A_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_vsync,
  input  logic              src_href,
  input  logic              src_clken,
  input  logic [DATA_W-1:0] src_img,
  input  logic              tx_vsync,
  input  logic              tx_href,
  input  logic              tx_clken,
  input  logic [TX_W-1:0]   tx_img,
  input  logic              a_valid,
  input  logic [7:0]        a_value,
  input  logic              err_clr,
  output logic              out_vsync,
  output logic              out_href,
  output logic              out_clken,
  output logic [DATA_W-1:0] out_img,
  output logic [TX_W-1:0]   out_tx,
  output logic [7:0]        out_A,
  output logic              ovf_err,
  output logic              udf_err,
  output logic              mis_err,
  output logic [ADDR_W:0]   hwm
);

  sched_state_t    state;
  logic            src_seen;
  logic            src_vs_d;
  logic            tx_vs_d;
  logic            src_rise;
  logic            tx_rise;
  logic            tx_fall;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ADDR_W:0] fifo_count;
  logic            fifo_flush;
  logic            ovf_set;
  logic            udf_set;
  logic            mis_set;
  logic [7:0]      a_shadow;

  // Pushes are strobed by src_clken alone; the line-valid qualifier carries no extra information here.
  logic unused_src_href;
  assign unused_src_href = src_href;

  assign src_rise   = src_vsync && !src_vs_d;
  assign tx_rise    = tx_vsync && !tx_vs_d;
  assign tx_fall    = !tx_vsync && tx_vs_d;
  assign fifo_flush = (state == ST_CHECK) && (fifo_count != '0);

  assign ovf_set = src_clken && fifo_full && !(tx_clken && !fifo_empty);
  assign udf_set = tx_clken && fifo_empty;
  assign mis_set = fifo_flush;

  haze_sync_fifo #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (src_clken),
    .wr_data (src_img),
    .rd_en   (tx_clken),
    .flush   (fifo_flush),
    .rd_data (out_img),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_vs_d  <= 1'b0;
      tx_vs_d   <= 1'b0;
      out_vsync <= 1'b0;
      out_href  <= 1'b0;
      out_clken <= 1'b0;
      out_tx    <= '0;
    end else begin
      src_vs_d  <= src_vsync;
      tx_vs_d   <= tx_vsync;
      out_vsync <= tx_vsync;
      out_href  <= tx_href;
      out_clken <= tx_clken;
      out_tx    <= tx_img;
    end
  end

  // A transfers at the tx frame start using the shadow value held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_shadow <= A_INIT;
      out_A    <= A_INIT;
    end else begin
      if (a_valid) a_shadow <= a_value;
      if (tx_rise) out_A    <= a_shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      src_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (src_rise) state <= ST_FILL;
        ST_FILL:  if (tx_rise) begin
                    state    <= ST_RUN;
                    src_seen <= 1'b0;
                  end
        ST_RUN:   begin
                    if (src_rise) src_seen <= 1'b1;
                    if (tx_fall)  state    <= ST_CHECK;
                  end
        ST_CHECK: state <= (src_seen || src_rise) ? ST_FILL : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
      mis_err <= 1'b0;
    end else begin
      ovf_err <= ovf_set || (ovf_err && !err_clr);
      udf_err <= udf_set || (udf_err && !err_clr);
      mis_err <= mis_set || (mis_err && !err_clr);
    end
  end

`ifdef HAZE_SCHED_HWM_EN
  logic [ADDR_W:0] hwm_track;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_track <= '0;
      hwm       <= '0;
    end else if (state == ST_CHECK) begin
      hwm       <= hwm_track;
      hwm_track <= '0;
    end else if (state == ST_RUN && fifo_count > hwm_track) begin
      hwm_track <= fifo_count;
    end
  end
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_haze_stream_sched.sv
// Directed self-checking bench for haze_stream_sched: alignment, A sequencing, errors, reset.
module tb_haze_stream_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_vsync, src_href, src_clken;
  logic [23:0] src_img;
  logic        tx_vsync, tx_href, tx_clken;
  logic [7:0]  tx_img;
  logic        a_valid;
  logic [7:0]  a_value;
  logic        err_clr;
  logic        out_vsync, out_href, out_clken;
  logic [23:0] out_img;
  logic [7:0]  out_tx;
  logic [7:0]  out_A;
  logic        ovf_err, udf_err, mis_err;
  logic [11:0] hwm;

  int checks = 0;
  int errors = 0;

  haze_stream_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_vsync (src_vsync),
    .src_href  (src_href),
    .src_clken (src_clken),
    .src_img   (src_img),
    .tx_vsync  (tx_vsync),
    .tx_href   (tx_href),
    .tx_clken  (tx_clken),
    .tx_img    (tx_img),
    .a_valid   (a_valid),
    .a_value   (a_value),
    .err_clr   (err_clr),
    .out_vsync (out_vsync),
    .out_href  (out_href),
    .out_clken (out_clken),
    .out_img   (out_img),
    .out_tx    (out_tx),
    .out_A     (out_A),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err),
    .mis_err   (mis_err),
    .hwm       (hwm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zeroInputs();
    src_vsync = 0; src_href = 0; src_clken = 0; src_img = '0;
    tx_vsync  = 0; tx_href  = 0; tx_clken  = 0; tx_img  = '0;
    a_valid   = 0; a_value  = '0; err_clr  = 0;
  endtask

  // Frame timing: vsync leads by 4 cycles, lines of cols pixels plus gap, 2-cycle tail.
  task automatic gen(input int t, input int lines, input int cols, input int gap, input int lim,
                     output logic vs, output logic hr, output logic ce, output int idx);
    int u, ln, col;
    vs = (t >= 0) && (t < 4 + lines * (cols + gap) + 2);
    hr = 0; ce = 0; idx = 0;
    if (t >= 4) begin
      u   = t - 4;
      ln  = u / (cols + gap);
      col = u % (cols + gap);
      hr  = (ln < lines) && (col < cols);
      idx = ln * cols + col;
      ce  = hr && (idx < lim);
    end
  endtask

  task automatic applyStimulus(input int lines, input int cols, input int gap,
                               input int src_lim, input int tx_lim, input int skew,
                               input int cycles, input int a_t, input logic [7:0] a_v,
                               input logic [7:0] a_before, input logic [7:0] a_after);
    logic svs, shr, sce, tvs, thr, tce;
    int   sidx, tidx;
    for (int t = 0; t < cycles; t++) begin
      gen(t, lines, cols, gap, src_lim, svs, shr, sce, sidx);
      gen(t - skew, lines, cols, gap, tx_lim, tvs, thr, tce, tidx);
      src_vsync = svs; src_href = shr; src_clken = sce;
      src_img   = {3{sidx[7:0]}};
      tx_vsync  = tvs; tx_href = thr; tx_clken = tce;
      tx_img    = tidx[7:0] ^ 8'h5a;
      a_valid   = (t == a_t);
      a_value   = a_v;
      step();
      checkOutput("sync", {29'd0, out_vsync, out_href, out_clken}, {29'd0, tvs, thr, tce});
      if (tce) begin
        checkOutput("img", {8'd0, out_img}, {8'd0, {3{tidx[7:0]}}});
        checkOutput("tx", {24'd0, out_tx}, {24'd0, tidx[7:0] ^ 8'h5a});
      end
      checkOutput("outA", {24'd0, out_A}, {24'd0, (t < skew) ? a_before : a_after});
    end
    zeroInputs();
  endtask

  task automatic checkErrs(input string tag, input logic [2:0] expv);
    checkOutput(tag, {29'd0, ovf_err, udf_err, mis_err}, {29'd0, expv});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sync"}, {29'd0, out_vsync, out_href, out_clken}, 32'd0);
    checkOutput({tag, "_img"}, {8'd0, out_img}, 32'd0);
    checkOutput({tag, "_tx"}, {24'd0, out_tx}, 32'd0);
    checkOutput({tag, "_A"}, {24'd0, out_A}, 32'd240);
    checkOutput({tag, "_hwm"}, {20'd0, hwm}, 32'd0);
    checkErrs({tag, "_err"}, 3'b000);
  endtask

  initial begin
    zeroInputs();
    rst_n = 0;
    step(); step();
    checkResetState("rst");
    rst_n = 1;
    repeat (3) step();

    // Frame 1: A update arrives mid-frame and must not show yet.
    applyStimulus(4, 8, 2, 32, 32, 100, 155, 120, 8'h90, 8'd240, 8'd240);
    checkErrs("f1_err", 3'b000);
    // Frame 2: A switches right after the tx frame start.
    applyStimulus(4, 8, 2, 32, 32, 100, 155, -1, 8'h00, 8'd240, 8'h90);
    checkErrs("f2_err", 3'b000);

    // Underflow: pop with empty FIFO, sticky until cleared, set wins over clear.
    tx_clken = 1; step(); tx_clken = 0;
    checkOutput("udf_img", {8'd0, out_img}, 32'd0);
    checkErrs("udf_set", 3'b010);
    repeat (5) step();
    checkErrs("udf_hold", 3'b010);
    tx_clken = 1; err_clr = 1; step(); tx_clken = 0;
    checkErrs("udf_setwins", 3'b010);
    step(); err_clr = 0;
    checkErrs("udf_clr", 3'b000);

    // Pixel-count mismatch: 32 in, 30 out.
    applyStimulus(4, 8, 2, 32, 30, 100, 155, -1, 8'h00, 8'h90, 8'h90);
    checkErrs("mis_set", 3'b001);
    err_clr = 1; step(); err_clr = 0;
    checkErrs("mis_clr", 3'b000);
    applyStimulus(4, 8, 2, 32, 32, 100, 155, -1, 8'h00, 8'h90, 8'h90);
    checkErrs("realign_err", 3'b000);

    // Continuous 1 pixel/cycle with 100-cycle skew.
    applyStimulus(1, 200, 0, 200, 200, 100, 316, -1, 8'h00, 8'h90, 8'h90);
    checkErrs("hwm_err", 3'b000);
`ifdef HAZE_SCHED_HWM_EN
    checkOutput("hwm100", {20'd0, hwm}, 32'd100);
`else
    checkOutput("hwm_off", {20'd0, hwm}, 32'd0);
`endif

    // Overflow: 2049 pushes with no pops, then drain 2048 plus one underflow.
    for (int k = 0; k < 2048; k++) begin
      src_clken = 1; src_img = 24'(k); step();
    end
    checkErrs("ovf_pre", 3'b000);
    src_img = 24'd2048; step(); src_clken = 0;
    checkErrs("ovf_set", 3'b100);
    for (int i = 0; i < 2048; i++) begin
      tx_clken = 1; step();
      checkOutput("ovf_pop", {8'd0, out_img}, 32'(i));
    end
    step(); tx_clken = 0;
    checkOutput("ovf_drain_img", {8'd0, out_img}, 32'd0);
    checkErrs("ovf_drain_err", 3'b110);
    err_clr = 1; step(); err_clr = 0;
    checkErrs("ovf_clr", 3'b000);

    // Reset mid-frame, then a clean frame with A back to its initial value.
    applyStimulus(4, 8, 2, 32, 32, 100, 120, 10, 8'h55, 8'h90, 8'h55);
    @(posedge clk); #1;
    rst_n = 0;
    #2;
    checkResetState("midrst");
    step(); step();
    rst_n = 1;
    repeat (3) step();
    applyStimulus(4, 8, 2, 32, 32, 100, 155, -1, 8'h00, 8'd240, 8'd240);
    checkErrs("post_rst_err", 3'b000);
`ifdef HAZE_SCHED_HWM_EN
    checkOutput("post_rst_hwm", {20'd0, hwm}, 32'd32);
`else
    checkOutput("post_rst_hwm", {20'd0, hwm}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
